// File: rtl/clock_time_controller_if.sv
// Button inputs and time/status outputs of the timekeeping controller.
// Master drives the buttons and observes the display fields; slave is the controller.
// No flow control: buttons are single-cycle pulses, outputs are valid every cycle.
interface clock_time_controller_if;
    logic       mode_btn;
    logic       inc_btn;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       sec_tick;
    logic       blink;

    modport master (
        output mode_btn, inc_btn,
        input  hours, minutes, seconds, mode, sec_tick, blink
    );

    modport slave (
        input  mode_btn, inc_btn,
        output hours, minutes, seconds, mode, sec_tick, blink
    );
endinterface

// File: rtl/clock_time_controller.sv
// HH:MM:SS 24-hour timekeeper with internal seconds prescaler and RUN/SET_HR/SET_MIN mode FSM.
// Latency: all outputs registered; time updates on the edge after sec_tick is high.
// No backpressure: button pulses are consumed the cycle they arrive (mode_btn beats inc_btn).
module clock_time_controller #(
    parameter int TICK_DIV = 50000000
) (
    input  logic                    clk_in,
    input  logic                    rst,
    clock_time_controller_if.slave  ctl
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_e;

    localparam int            CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0] PRE_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] PRE_ONE  = CW'(1);

    mode_e         mode_q,  mode_d;
    logic [CW-1:0] pre_q,   pre_d;
    logic          tick_q,  tick_d;
    logic          blink_q, blink_d;
    logic [4:0]    hours_q, hours_d;
    logic [5:0]    min_q,   min_d;
    logic [5:0]    sec_q,   sec_d;

    // Next state: prescaler, time fields, blink and mode, with mode_btn taking priority over inc_btn.
    always_comb begin
        mode_d  = mode_q;
        blink_d = blink_q;
        hours_d = hours_q;
        min_d   = min_q;
        sec_d   = sec_q;
        // The prescaler free-runs in every mode; the strobe is high for the cycle after the last count.
        pre_d   = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_ONE;
        tick_d  = (pre_q == PRE_LAST);

        case (mode_q)
            RUN: begin
                blink_d = 1'b1;
                // Full cascade on one edge so 23:59:59 rolls straight to 00:00:00.
                if (tick_q) begin
                    if (sec_q == 6'd59) begin
                        sec_d = 6'd0;
                        if (min_q == 6'd59) begin
                            min_d   = 6'd0;
                            hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
                if (ctl.mode_btn) begin
                    mode_d = SET_HR;
                end
            end
            SET_HR: begin
                if (ctl.mode_btn) begin
                    mode_d  = SET_MIN;
                    blink_d = 1'b1;
                end else begin
                    if (ctl.inc_btn) begin
                        hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                    end
                    if (tick_q) begin
                        blink_d = ~blink_q;
                    end
                end
            end
            SET_MIN: begin
                if (ctl.mode_btn) begin
                    // Restart timing from a whole second with the freshly set minutes.
                    mode_d  = RUN;
                    blink_d = 1'b1;
                    sec_d   = 6'd0;
                    pre_d   = '0;
                    tick_d  = 1'b0;
                end else begin
                    if (ctl.inc_btn) begin
                        min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                    end
                    if (tick_q) begin
                        blink_d = ~blink_q;
                    end
                end
            end
            default: begin
                mode_d  = RUN;
                blink_d = 1'b1;
            end
        endcase
    end

    // State registers with synchronous reset to 00:00:00 in RUN.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            mode_q  <= RUN;
            pre_q   <= '0;
            tick_q  <= 1'b0;
            blink_q <= 1'b1;
            hours_q <= 5'd0;
            min_q   <= 6'd0;
            sec_q   <= 6'd0;
        end else begin
            mode_q  <= mode_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            blink_q <= blink_d;
            hours_q <= hours_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
        end
    end

    assign ctl.hours    = hours_q;
    assign ctl.minutes  = min_q;
    assign ctl.seconds  = sec_q;
    assign ctl.mode     = mode_q;
    assign ctl.sec_tick = tick_q;
    assign ctl.blink    = blink_q;

endmodule

// File: tb/tb_clock_time_controller.sv
// Scoreboard bench for clock_time_controller with TICK_DIV=4.
// Expected outputs come from a seconds-of-day reference model, one entry per clock edge.
// A separate monitor pops one entry per edge and compares every output field.
module tb_clock_time_controller;

    localparam int TD = 4;

    logic clk_in = 1'b0;
    logic rst;

    clock_time_controller_if ctl();

    clock_time_controller #(.TICK_DIV(TD)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .ctl    (ctl)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] mode;
        logic       tick;
        logic       blink;
    } exp_t;

    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state: time of day, mode, blink and edges since the prescaler last restarted.
    int m_h = 0, m_m = 0, m_s = 0, m_mode = 0, m_blink = 1, m_tick = 0, m_since = 0;

    task automatic model_edge(input logic r, input logic mb, input logic ib);
        int  t;
        bit  restart;
        restart = 1'b0;
        if (r) begin
            m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_blink = 1;
            restart = 1'b1;
        end else begin
            if (m_mode == 0) begin
                if (m_tick != 0) begin
                    t   = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                    m_h = t / 3600;
                    m_m = (t / 60) % 60;
                    m_s = t % 60;
                end
                m_blink = 1;
                if (mb) m_mode = 1;
            end else if (mb) begin
                m_blink = 1;
                if (m_mode == 1) begin
                    m_mode = 2;
                end else begin
                    m_mode  = 0;
                    m_s     = 0;
                    restart = 1'b1;
                end
            end else begin
                if (ib && m_mode == 1) m_h = (m_h + 1) % 24;
                if (ib && m_mode == 2) m_m = (m_m + 1) % 60;
                if (m_tick != 0) m_blink = 1 - m_blink;
            end
        end
        m_since = restart ? 0 : m_since + 1;
        m_tick  = (m_since > 0 && (m_since % TD) == 0) ? 1 : 0;
    endtask

    task automatic step(input logic r, input logic mb, input logic ib);
        exp_t e;
        @(negedge clk_in);
        rst          = r;
        ctl.mode_btn = mb;
        ctl.inc_btn  = ib;
        model_edge(r, mb, ib);
        e.h     = 5'(m_h);
        e.m     = 6'(m_m);
        e.s     = 6'(m_s);
        e.mode  = 2'(m_mode);
        e.tick  = (m_tick != 0);
        e.blink = (m_blink != 0);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic inc(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: outputs are valid every cycle, so one expected entry is consumed per edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (ctl.hours !== e.h || ctl.minutes !== e.m || ctl.seconds !== e.s ||
                    ctl.mode !== e.mode || ctl.sec_tick !== e.tick || ctl.blink !== e.blink) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got %0d:%0d:%0d mode=%0d tick=%0d blink=%0d expected %0d:%0d:%0d mode=%0d tick=%0d blink=%0d",
                             cyc, ctl.hours, ctl.minutes, ctl.seconds, ctl.mode, ctl.sec_tick, ctl.blink,
                             e.h, e.m, e.s, e.mode, e.tick, e.blink);
                end
            end
        end
    end

    initial begin : stimulus
        rst          = 1'b1;
        ctl.mode_btn = 1'b0;
        ctl.inc_btn  = 1'b0;

        // Reset, then free-run: tick every 4th cycle, seconds 0..3.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(12);

        // Into SET_HR, 25 increments wrap hours to 1.
        step(1'b0, 1'b1, 1'b0);
        inc(25);
        idle(6);

        // mode_btn and inc_btn together: mode advances, hours untouched.
        step(1'b0, 1'b1, 1'b1);

        // SET_MIN: wrap minutes 59 -> 0, watch blink, then set minutes to 59.
        inc(60);
        idle(9);
        inc(59);

        // Back to RUN, set hours to 23, return via SET_MIN, run past midnight.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        inc(22);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(60 * TD + 8);

        // Reset in the middle of SET_MIN editing.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        inc(3);
        step(1'b1, 1'b0, 1'b0);
        idle(8);

        // mode_btn on the same edge as a RUN tick: tick applied and mode moves on.
        step(1'b1, 1'b0, 1'b0);
        idle(TD);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(TD + 2);

        // Random buttons and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 500) == 0, ($urandom % 8) == 0, ($urandom % 3) == 0);
        end
        idle(4);

        repeat (3) @(posedge clk_in);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
